// File: rtl/matrix_operand_loader.sv
// Operand loader for the 3x3 matrix multiplier.
// Collects 18 stream elements (A[0..8] then B[0..8]) into a working buffer.
// A completed frame is published as two flat buses behind a valid/ready handshake.
// A gap timeout discards stalled partial frames, and clr aborts everything in flight.
module matrix_operand_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [9*DATA_WIDTH-1:0] a_flat,
    output logic [9*DATA_WIDTH-1:0] b_flat,
    output logic                    mat_valid,
    input  logic                    mat_ready,
    output logic [4:0]              frame_idx,
    output logic                    timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [4:0] LAST = 5'd17;

    logic [4:0]                       idx_q,   idx_d;
    logic [TW-1:0]                    timer_q, timer_d;
    logic [17:0][DATA_WIDTH-1:0]      wbuf_q,  wbuf_d;
    logic [9*DATA_WIDTH-1:0]          a_q,     a_d;
    logic [9*DATA_WIDTH-1:0]          b_q,     b_d;
    logic                             mv_q,    mv_d;
    logic                             err_q,   err_d;

    logic stall, accept;

    // Only the completing byte stalls: it would overwrite an output frame not yet taken.
    assign stall    = (idx_q == LAST) && mv_q && !mat_ready;
    assign in_ready = !stall;
    // clr drops any byte presented in its cycle even though in_ready may read 1.
    assign accept   = in_valid && in_ready && !clr;

    // Next-state: clr first, then byte acceptance (which beats a same-cycle timeout), then idle timing.
    always_comb begin
        idx_d   = idx_q;
        timer_d = timer_q;
        wbuf_d  = wbuf_q;
        a_d     = a_q;
        b_d     = b_q;
        mv_d    = mv_q;
        err_d   = 1'b0;
        if (clr) begin
            idx_d   = '0;
            timer_d = '0;
            mv_d    = 1'b0;
        end else begin
            if (mv_q && mat_ready)
                mv_d = 1'b0;
            if (accept) begin
                for (int i = 0; i < 18; i++)
                    if (idx_q == 5'(i))
                        wbuf_d[i] = in_data;
                timer_d = '0;
                if (idx_q == LAST) begin
                    // Publish the buffer including the byte landing this cycle.
                    idx_d = '0;
                    mv_d  = 1'b1;
                    a_d   = wbuf_d[8:0];
                    b_d   = wbuf_d[17:9];
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end else if (idx_q == '0) begin
                timer_d = '0;
            end else if (!stall && (TIMEOUT_CYCLES > 0)) begin
                // Partial frame sitting idle; the working buffer is left as is.
                if (timer_q == TLIM) begin
                    idx_d   = '0;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            timer_q <= '0;
            wbuf_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            timer_q <= timer_d;
            wbuf_q  <= wbuf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mv_q    <= mv_d;
            err_q   <= err_d;
        end
    end

    assign a_flat      = a_q;
    assign b_flat      = b_q;
    assign mat_valid   = mv_q;
    assign frame_idx   = idx_q;
    assign timeout_err = err_q;

endmodule
